// File: rtl/vx_dma_chan_mem_arb_if.sv
// Bundle of channel-side and memory-side signals for the DMA channel memory arbiter.
// Latency: none (wires only); timing is defined by the arbiter that uses the slave modport.
// Backpressure: ch_req_ready / mem_req_ready / ch_rsp_ready / mem_rsp_ready valid-ready pairs.
interface vx_dma_chan_mem_arb_if #(
  parameter int NUM_CHANNELS    = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SEQ_BITS  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TAG_WIDTH = CH_BITS + SEQ_BITS;

  // channel request side
  logic [NUM_CHANNELS-1:0]            ch_req_valid;
  logic [NUM_CHANNELS-1:0]            ch_req_rw;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_req_addr;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_req_data;
  logic [NUM_CHANNELS-1:0]            ch_req_ready;
  // channel response side
  logic [NUM_CHANNELS-1:0]            ch_rsp_valid;
  logic [NUM_CHANNELS-1:0]            ch_rsp_ready;
  // memory request side
  logic                               mem_req_valid;
  logic                               mem_req_rw;
  logic [ADDR_WIDTH-1:0]              mem_req_addr;
  logic [DATA_WIDTH-1:0]              mem_req_data;
  logic [TAG_WIDTH-1:0]               mem_req_tag;
  logic                               mem_req_ready;
  // memory response side
  logic                               mem_rsp_valid;
  logic [TAG_WIDTH-1:0]               mem_rsp_tag;
  logic                               mem_rsp_ready;
  // status
  logic [NUM_CHANNELS-1:0]            ch_busy;
  logic                               err_seq;

  // channels plus memory model: drives requests, readies and responses
  modport master (
    output ch_req_valid, ch_req_rw, ch_req_addr, ch_req_data, ch_rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_tag,
    input  ch_req_ready, ch_rsp_valid, mem_req_valid, mem_req_rw, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready, ch_busy, err_seq
  );

  // the arbiter itself
  modport slave (
    input  ch_req_valid, ch_req_rw, ch_req_addr, ch_req_data, ch_rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_tag,
    output ch_req_ready, ch_rsp_valid, mem_req_valid, mem_req_rw, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready, ch_busy, err_seq
  );
endinterface

// File: rtl/vx_dma_chan_mem_arb.sv
// Round-robin arbiter sharing one tagged memory request port among DMA channels, routing responses back by tag.
// Latency: a granted request appears on mem_req_* one cycle after the grant; responses route combinationally.
// Backpressure: the single output slot holds while mem_req_ready=0; a channel at its outstanding limit is skipped.
module vx_dma_chan_mem_arb #(
  parameter int NUM_CHANNELS    = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_dma_chan_mem_arb_if.slave   bus
);
  localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SEQ_BITS  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TAG_WIDTH = CH_BITS + SEQ_BITS;
  localparam int CNT_BITS  = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [CH_BITS-1:0]  ch_t;
  typedef logic [SEQ_BITS-1:0] seq_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  localparam cnt_t CNT_MAX  = cnt_t'(MAX_OUTSTANDING);
  localparam seq_t SEQ_LAST = seq_t'(MAX_OUTSTANDING - 1);
  localparam ch_t  CH_LAST  = ch_t'(NUM_CHANNELS - 1);

  // output slot and per-channel bookkeeping
  logic valid_q, valid_d;
  req_t req_q, req_d;
  ch_t  rr_q, rr_d;
  logic err_q, err_d;
  cnt_t cnt_q  [NUM_CHANNELS];
  cnt_t cnt_d  [NUM_CHANNELS];
  seq_t iseq_q [NUM_CHANNELS];
  seq_t iseq_d [NUM_CHANNELS];
  seq_t eseq_q [NUM_CHANNELS];
  seq_t eseq_d [NUM_CHANNELS];

  logic                    slot_free;
  logic [NUM_CHANNELS-1:0] eligible;
  logic                    gnt_vld;
  ch_t                     gnt_id;
  logic [NUM_CHANNELS-1:0] gnt_oh;

  ch_t                     rsp_ch;
  seq_t                    rsp_seq;
  logic                    tag_ok;
  logic [NUM_CHANNELS-1:0] rsp_oh;
  logic                    rsp_fire;

  assign slot_free = ~valid_q | bus.mem_req_ready;
  assign rsp_ch    = bus.mem_rsp_tag[TAG_WIDTH-1 -: CH_BITS];
  assign rsp_seq   = bus.mem_rsp_tag[SEQ_BITS-1:0];

  // channel ids beyond NUM_CHANNELS only exist when the count is not a power of two
  generate
    if (NUM_CHANNELS == (1 << CH_BITS)) begin : g_tag_full
      assign tag_ok = 1'b1;
    end else begin : g_tag_part
      assign tag_ok = (int'(rsp_ch) < NUM_CHANNELS);
    end
  endgenerate

  // eligibility: requesting and still below the in-flight limit
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = bus.ch_req_valid[i] & (cnt_q[i] < CNT_MAX);
    end
  end

  // round-robin scan starting at rr_q; first eligible channel wins when the slot can take it
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!gnt_vld && eligible[(int'(rr_q) + k) % NUM_CHANNELS]) begin
        gnt_vld = 1'b1;
        gnt_id  = ch_t'((int'(rr_q) + k) % NUM_CHANNELS);
      end
    end
    gnt_vld = gnt_vld & slot_free;
    gnt_oh  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_id == ch_t'(i));
    end
  end

  // response decode: one-hot channel select, bad ids are swallowed
  always_comb begin
    rsp_oh = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rsp_oh[i] = tag_ok && (rsp_ch == ch_t'(i));
    end
  end

  assign rsp_fire = bus.mem_rsp_valid & bus.mem_rsp_ready;

  // next state: output slot load/drain, rr pointer, per-channel counters and sticky error
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    rr_d    = rr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    iseq_d  = iseq_q;
    eseq_d  = eseq_q;

    if (gnt_vld) begin
      valid_d    = 1'b1;
      req_d.rw   = bus.ch_req_rw[gnt_id];
      req_d.addr = bus.ch_req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      req_d.data = bus.ch_req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      req_d.tag  = {gnt_id, iseq_q[gnt_id]};
      rr_d       = (gnt_id == CH_LAST) ? '0 : gnt_id + ch_t'(1);
    end else if (bus.mem_req_ready) begin
      valid_d = 1'b0;
    end

    if (rsp_fire && !tag_ok) begin
      err_d = 1'b1;
    end

    for (int i = 0; i < NUM_CHANNELS; i++) begin
      logic dec;
      dec = 1'b0;
      if (gnt_oh[i]) begin
        iseq_d[i] = (iseq_q[i] == SEQ_LAST) ? '0 : iseq_q[i] + seq_t'(1);
      end
      if (rsp_fire && rsp_oh[i]) begin
        if (cnt_q[i] == '0) begin
          // spurious response: nothing in flight to retire
          err_d = 1'b1;
        end else begin
          dec       = 1'b1;
          eseq_d[i] = (eseq_q[i] == SEQ_LAST) ? '0 : eseq_q[i] + seq_t'(1);
          if (rsp_seq != eseq_q[i]) begin
            err_d = 1'b1;
          end
        end
      end
      case ({gnt_oh[i], dec})
        2'b10:   cnt_d[i] = cnt_q[i] + cnt_t'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - cnt_t'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // state registers with synchronous active-low reset; in-flight tags are forgotten
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        iseq_q[i] <= '0;
        eseq_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      iseq_q  <= iseq_d;
      eseq_q  <= eseq_d;
    end
  end

  // busy flags straight from the counter registers
  always_comb begin
    bus.ch_busy = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      bus.ch_busy[i] = (cnt_q[i] != '0);
    end
  end

  assign bus.ch_req_ready  = gnt_oh;
  assign bus.mem_req_valid = valid_q;
  assign bus.mem_req_rw    = req_q.rw;
  assign bus.mem_req_addr  = req_q.addr;
  assign bus.mem_req_data  = req_q.data;
  assign bus.mem_req_tag   = req_q.tag;
  assign bus.ch_rsp_valid  = rsp_oh & {NUM_CHANNELS{bus.mem_rsp_valid}};
  assign bus.mem_rsp_ready = tag_ok ? |(rsp_oh & bus.ch_rsp_ready) : 1'b1;
  assign bus.err_seq       = err_q;
endmodule

// File: tb/tb_vx_dma_chan_mem_arb.sv
// Bench for the DMA channel memory arbiter: directed scenarios plus a randomized run against a reference model.
// Latency: inputs change 1ns after posedge; registered outputs are sampled 1ns after posedge.
// Backpressure: memory ready and channel response ready are driven both directed and at random.
module tb_vx_dma_chan_mem_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  vx_dma_chan_mem_arb_if #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

  vx_dma_chan_mem_arb #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model: counts and sequence numbers per channel, plus the expected output slot
  int              m_rr;
  int              m_cnt  [N];
  int              m_iseq [N];
  int              m_eseq [N];
  bit              m_err;
  bit              m_vld;
  logic            m_rw;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [TW-1:0]   m_tag;
  logic [TW-1:0]   pend[$];

  task automatic model_reset();
    m_rr = 0; m_err = 0; m_vld = 0; m_rw = 0; m_addr = '0; m_data = '0; m_tag = '0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_iseq[i] = 0; m_eseq[i] = 0; end
    pend.delete();
  endtask

  // who should win right now, from the arbitration rules; -1 when nobody
  function automatic int model_grant();
    if (m_vld && !bus.mem_req_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (bus.ch_req_valid[c] && m_cnt[c] < MO) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g, c, s;
    if (!reset) begin model_reset(); return; end
    g = model_grant();
    if (bus.mem_rsp_valid) begin
      c = int'(bus.mem_rsp_tag[3:2]);
      s = int'(bus.mem_rsp_tag[1:0]);
      if (bus.ch_rsp_ready[c]) begin
        if (m_cnt[c] == 0) m_err = 1;
        else begin
          if (s != m_eseq[c]) m_err = 1;
          m_eseq[c] = (m_eseq[c] + 1) % MO;
          m_cnt[c]--;
        end
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k] == bus.mem_rsp_tag) begin pend.delete(k); break; end
        end
      end
    end
    if (m_vld && bus.mem_req_ready) pend.push_back(m_tag);
    if (g >= 0) begin
      m_vld  = 1;
      m_rw   = bus.ch_req_rw[g];
      m_addr = bus.ch_req_addr[g*AW +: AW];
      m_data = bus.ch_req_data[g*DW +: DW];
      m_tag  = {2'(g), 2'(m_iseq[g])};
      m_iseq[g] = (m_iseq[g] + 1) % MO;
      m_cnt[g]++;
      m_rr = (g + 1) % N;
    end else if (bus.mem_req_ready) begin
      m_vld = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ch_req_valid = '0; bus.ch_req_rw = '0; bus.ch_req_addr = '0; bus.ch_req_data = '0;
    bus.ch_rsp_ready = '0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    tests_run++; if (bus.mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_vld got=%b exp=0", bus.mem_req_valid); end
    tests_run++; if (bus.mem_req_tag !== 4'b0 || bus.mem_req_addr !== 32'b0 || bus.mem_req_rw !== 1'b0 || bus.mem_req_data !== 64'b0) begin
      tests_failed++; $display("FAIL reset_slot tag=%h addr=%h rw=%b data=%h exp all 0", bus.mem_req_tag, bus.mem_req_addr, bus.mem_req_rw, bus.mem_req_data); end
    tests_run++; if (bus.ch_busy !== 4'b0 || bus.err_seq !== 1'b0) begin tests_failed++; $display("FAIL reset_status busy=%b err=%b exp 0/0", bus.ch_busy, bus.err_seq); end
    tests_run++; if (bus.ch_req_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_idle_ready got=%b exp=0000", bus.ch_req_ready); end
    bus.ch_req_valid = 4'b1111;
    #1;
    tests_run++; if (bus.ch_req_ready !== 4'b0001) begin tests_failed++; $display("FAIL reset_rr_start got=%b exp=0001", bus.ch_req_ready); end
    bus.ch_req_valid = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    bus.mem_req_ready = 1'b1; bus.ch_req_valid = 4'b0010; bus.ch_req_rw = 4'b0000;
    bus.ch_req_addr[1*AW +: AW] = 32'h1000; bus.ch_req_data[1*DW +: DW] = 64'hDEAD_BEEF_0123_4567;
    #2;
    tests_run++; if (bus.ch_req_ready !== 4'b0010) begin tests_failed++; $display("FAIL single_grant got=%b exp=0010", bus.ch_req_ready); end
    tick();
    bus.ch_req_valid = 4'b0000;
    tests_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h1000 || bus.mem_req_tag !== 4'b0100 || bus.mem_req_rw !== 1'b0) begin
      tests_failed++; $display("FAIL single_issue vld=%b addr=%h tag=%b rw=%b exp 1/1000/0100/0", bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_tag, bus.mem_req_rw); end
    tests_run++; if (bus.ch_busy !== 4'b0010) begin tests_failed++; $display("FAIL single_busy got=%b exp=0010", bus.ch_busy); end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'b0100; bus.ch_rsp_ready = 4'b1111;
    #2;
    tests_run++; if (bus.ch_rsp_valid !== 4'b0010 || bus.mem_rsp_ready !== 1'b1) begin
      tests_failed++; $display("FAIL single_route rsp_vld=%b rdy=%b exp 0010/1", bus.ch_rsp_valid, bus.mem_rsp_ready); end
    tick();
    bus.mem_rsp_valid = 1'b0;
    tests_run++; if (bus.ch_busy !== 4'b0000 || bus.err_seq !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_done busy=%b err=%b vld=%b exp 0000/0/0", bus.ch_busy, bus.err_seq, bus.mem_req_valid); end
  endtask

  task automatic test_fairness();
    int got [N];
    do_reset();
    for (int i = 0; i < N; i++) got[i] = 0;
    bus.mem_req_ready = 1'b1; bus.ch_req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      #2;
      for (int i = 0; i < N; i++) if (bus.ch_req_ready[i]) got[i]++;
      tests_run++; if (bus.ch_req_ready !== 4'(1 << (k % N))) begin
        tests_failed++; $display("FAIL fair_order k=%0d got=%b exp=%b", k, bus.ch_req_ready, 4'(1 << (k % N))); end
      tick();
      tests_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_tag !== {2'(k % N), 2'(k / N)}) begin
        tests_failed++; $display("FAIL fair_b2b k=%0d vld=%b tag=%b exp 1/%b", k, bus.mem_req_valid, bus.mem_req_tag, {2'(k % N), 2'(k / N)}); end
    end
    for (int i = 0; i < N; i++) begin
      tests_run++; if (got[i] != 3) begin tests_failed++; $display("FAIL fair_share ch=%0d got=%0d exp=3", i, got[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mem_req_ready = 1'b1; bus.ch_req_valid = 4'b0001; bus.ch_req_rw = 4'b0001;
    bus.ch_req_addr[0 +: AW] = 32'hA0; bus.ch_req_data[0 +: DW] = 64'h1111;
    #2;
    tests_run++; if (bus.ch_req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bp_first got=%b exp=0001", bus.ch_req_ready); end
    tick();
    bus.ch_req_addr[0 +: AW] = 32'hB0; bus.ch_req_data[0 +: DW] = 64'h2222; bus.mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      tests_run++; if (bus.ch_req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_noready k=%0d got=%b exp=0000", k, bus.ch_req_ready); end
      tests_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'hA0 || bus.mem_req_data !== 64'h1111 || bus.mem_req_tag !== 4'b0000) begin
        tests_failed++; $display("FAIL bp_hold k=%0d vld=%b addr=%h data=%h tag=%b exp 1/a0/1111/0000", k, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data, bus.mem_req_tag); end
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #2;
    tests_run++; if (bus.ch_req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bp_release got=%b exp=0001", bus.ch_req_ready); end
    tick();
    tests_run++; if (bus.mem_req_addr !== 32'hB0 || bus.mem_req_tag !== 4'b0001) begin
      tests_failed++; $display("FAIL bp_next addr=%h tag=%b exp b0/0001", bus.mem_req_addr, bus.mem_req_tag); end
  endtask

  task automatic test_limit();
    do_reset();
    bus.mem_req_ready = 1'b1; bus.ch_req_valid = 4'b0100;
    for (int k = 0; k < MO; k++) tick();
    #2;
    tests_run++; if (bus.ch_req_ready !== 4'b0000 || bus.ch_busy !== 4'b0100) begin
      tests_failed++; $display("FAIL limit_full ready=%b busy=%b exp 0000/0100", bus.ch_req_ready, bus.ch_busy); end
    bus.ch_req_valid = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++; if (bus.ch_req_ready !== 4'b1000) begin tests_failed++; $display("FAIL limit_skip k=%0d got=%b exp=1000", k, bus.ch_req_ready); end
      tick();
    end
    bus.ch_req_valid = 4'b0000; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'b1000; bus.ch_rsp_ready = 4'b0100;
    #2;
    tests_run++; if (bus.ch_rsp_valid !== 4'b0100 || bus.mem_rsp_ready !== 1'b1) begin
      tests_failed++; $display("FAIL limit_rsp vld=%b rdy=%b exp 0100/1", bus.ch_rsp_valid, bus.mem_rsp_ready); end
    tick();
    bus.mem_rsp_valid = 1'b0; bus.ch_req_valid = 4'b0100;
    #2;
    tests_run++; if (bus.ch_req_ready !== 4'b0100) begin tests_failed++; $display("FAIL limit_regrant got=%b exp=0100", bus.ch_req_ready); end
    tick();
    tests_run++; if (bus.mem_req_tag !== 4'b1000) begin tests_failed++; $display("FAIL limit_seqwrap got=%b exp=1000", bus.mem_req_tag); end
  endtask

  task automatic test_ordering();
    do_reset();
    bus.mem_req_ready = 1'b1; bus.ch_req_valid = 4'b0001;
    tick(); tick();
    bus.ch_req_valid = 4'b0000; bus.ch_rsp_ready = 4'b1111; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'b0001;
    tick();
    tests_run++; if (bus.err_seq !== 1'b1 || bus.ch_busy !== 4'b0001) begin
      tests_failed++; $display("FAIL order_err err=%b busy=%b exp 1/0001", bus.err_seq, bus.ch_busy); end
    tick();
    bus.mem_rsp_valid = 1'b0;
    tests_run++; if (bus.ch_busy !== 4'b0000) begin tests_failed++; $display("FAIL order_drain busy=%b exp=0000", bus.ch_busy); end
    tick(); tick(); tick();
    tests_run++; if (bus.err_seq !== 1'b1) begin tests_failed++; $display("FAIL order_sticky err=%b exp=1", bus.err_seq); end
    do_reset();
    tests_run++; if (bus.err_seq !== 1'b0) begin tests_failed++; $display("FAIL order_clear err=%b exp=0", bus.err_seq); end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.ch_rsp_ready = 4'b1111; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 4'b1100;
    #2;
    tests_run++; if (bus.ch_rsp_valid !== 4'b1000 || bus.mem_rsp_ready !== 1'b1) begin
      tests_failed++; $display("FAIL uflow_route vld=%b rdy=%b exp 1000/1", bus.ch_rsp_valid, bus.mem_rsp_ready); end
    tick();
    bus.mem_rsp_valid = 1'b0;
    tests_run++; if (bus.err_seq !== 1'b1 || bus.ch_busy !== 4'b0000) begin
      tests_failed++; $display("FAIL uflow_err err=%b busy=%b exp 1/0000", bus.err_seq, bus.ch_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mem_req_ready = 1'b1; bus.ch_req_valid = 4'b0111;
    tick(); tick(); tick();
    bus.ch_req_valid = 4'b0000;
    tests_run++; if (bus.ch_busy !== 4'b0111) begin tests_failed++; $display("FAIL rmid_pre busy=%b exp=0111", bus.ch_busy); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests_run++; if (bus.mem_req_valid !== 1'b0 || bus.ch_busy !== 4'b0000 || bus.err_seq !== 1'b0) begin
      tests_failed++; $display("FAIL rmid_state vld=%b busy=%b err=%b exp 0/0000/0", bus.mem_req_valid, bus.ch_busy, bus.err_seq); end
    bus.ch_req_valid = 4'b0010;
    tick();
    tests_run++; if (bus.mem_req_tag !== 4'b0100 || bus.mem_req_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_seq0 tag=%b vld=%b exp 0100/1", bus.mem_req_tag, bus.mem_req_valid); end
  endtask

  task automatic test_random();
    int g, j, k;
    logic [3:0] exp_oh, exp_busy, exp_rv;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.ch_req_valid  = 4'($urandom);
      bus.ch_req_rw     = 4'($urandom);
      for (int c = 0; c < N; c++) begin
        bus.ch_req_addr[c*AW +: AW] = $urandom;
        bus.ch_req_data[c*DW +: DW] = {$urandom, $urandom};
      end
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.ch_rsp_ready  = 4'($urandom);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, pend.size() - 1);
        k = 0;
        while (pend[k][3:2] != pend[j][3:2]) k++;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = pend[k];
      end else begin
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = 4'($urandom);
      end
      #2;
      g = model_grant();
      exp_oh = (g < 0) ? 4'b0 : 4'(1 << g);
      exp_rv = bus.mem_rsp_valid ? 4'(1 << bus.mem_rsp_tag[3:2]) : 4'b0;
      tests_run++; if (bus.ch_req_ready !== exp_oh) begin tests_failed++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, bus.ch_req_ready, exp_oh); end
      tests_run++; if (bus.ch_rsp_valid !== exp_rv || bus.mem_rsp_ready !== bus.ch_rsp_ready[bus.mem_rsp_tag[3:2]]) begin
        tests_failed++; $display("FAIL rnd_route cyc=%0d vld=%b rdy=%b exp %b/%b", cyc, bus.ch_rsp_valid, bus.mem_rsp_ready, exp_rv, bus.ch_rsp_ready[bus.mem_rsp_tag[3:2]]); end
      tick();
      for (int c = 0; c < N; c++) exp_busy[c] = (m_cnt[c] != 0);
      tests_run++; if (bus.mem_req_valid !== m_vld) begin tests_failed++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, bus.mem_req_valid, m_vld); end
      if (m_vld) begin
        tests_run++; if (bus.mem_req_rw !== m_rw || bus.mem_req_addr !== m_addr || bus.mem_req_data !== m_data || bus.mem_req_tag !== m_tag) begin
          tests_failed++; $display("FAIL rnd_req cyc=%0d rw=%b addr=%h data=%h tag=%b exp %b/%h/%h/%b", cyc, bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data, bus.mem_req_tag, m_rw, m_addr, m_data, m_tag); end
      end
      tests_run++; if (bus.ch_busy !== exp_busy || bus.err_seq !== m_err) begin
        tests_failed++; $display("FAIL rnd_status cyc=%0d busy=%b err=%b exp %b/%b", cyc, bus.ch_busy, bus.err_seq, exp_busy, m_err); end
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_limit();
    test_ordering();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
